// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the DE1 SRAM arbiter: FSM states, port
// identifiers and the SRAM halfword address width.
package sram_arbiter_pkg;

    localparam int SRAM_AW = 18;
    localparam int WORD_AW = SRAM_AW - 1;

    typedef enum logic [2:0] {
        IDLE,
        LO_SETUP,
        LO_STROBE,
        HI_SETUP,
        HI_STROBE,
        DONE
    } state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } port_t;

endpackage

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing a 16-bit asynchronous SRAM between the instruction
// and data ports; each 32-bit word is two halfword accesses, low half first.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_req,
    input  logic [WORD_AW-1:0] i_addr,
    output logic               i_ack,
    output logic [31:0]        i_rdata,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [3:0]         d_be,
    input  logic [WORD_AW-1:0] d_addr,
    input  logic [31:0]        d_wdata,
    output logic               d_ack,
    output logic [31:0]        d_rdata,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [15:0]        sram_dq_i,
    output logic [15:0]        sram_dq_o,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam logic [1:0] CNT_INIT = 2'(WAIT_STATES);

    state_t             state, state_nx;
    port_t              grant, last_grant, pick;
    logic [WORD_AW-1:0] addr_q;
    logic               we_q;
    logic [3:0]         be_q;
    logic [31:0]        wdata_q;
    logic [15:0]        lo_q;
    logic [1:0]         cnt;
    logic               half, active, strobe, strobe_last;

    assign strobe_last = (cnt == 2'd0);

    // Under contention the port that was not served last wins.
    always_comb begin
        if (i_req && d_req)
            pick = (last_grant == PORT_I) ? PORT_D : PORT_I;
        else if (d_req)
            pick = PORT_D;
        else
            pick = PORT_I;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_nx   = state;
        half       = (state == HI_SETUP) || (state == HI_STROBE);
        active     = (state != IDLE) && (state != DONE);
        strobe     = (state == LO_STROBE) || (state == HI_STROBE);
        sram_addr  = {addr_q, half};
        sram_ce_n  = !active;
        sram_oe_n  = !(strobe && !we_q);
        sram_we_n  = !(strobe && we_q);
        sram_dq_oe = active && we_q;
        sram_dq_o  = 16'h0;
        sram_ub_n  = 1'b1;
        sram_lb_n  = 1'b1;

        if (sram_dq_oe)
            sram_dq_o = half ? wdata_q[31:16] : wdata_q[15:0];

        if (strobe) begin
            if (we_q) begin
                sram_lb_n = half ? !be_q[2] : !be_q[0];
                sram_ub_n = half ? !be_q[3] : !be_q[1];
            end else begin
                sram_lb_n = 1'b0;
                sram_ub_n = 1'b0;
            end
        end

        case (state)
            IDLE:      if (i_req || d_req) state_nx = LO_SETUP;
            LO_SETUP:  state_nx = LO_STROBE;
            LO_STROBE: if (strobe_last) state_nx = HI_SETUP;
            HI_SETUP:  state_nx = HI_STROBE;
            HI_STROBE: if (strobe_last) state_nx = DONE;
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= PORT_I;
            last_grant <= PORT_I;
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= 4'h0;
            wdata_q    <= 32'h0;
            lo_q       <= 16'h0;
            cnt        <= 2'd0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= 32'h0;
            d_rdata    <= 32'h0;
        end else begin
            state <= state_nx;
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        grant <= pick;
                        if (pick == PORT_D) begin
                            addr_q  <= d_addr;
                            we_q    <= d_we;
                            be_q    <= d_be;
                            wdata_q <= d_wdata;
                        end else begin
                            addr_q  <= i_addr;
                            we_q    <= 1'b0;
                            be_q    <= 4'hF;
                            wdata_q <= 32'h0;
                        end
                    end
                end
                LO_SETUP, HI_SETUP: cnt <= CNT_INIT;
                LO_STROBE: begin
                    if (!strobe_last) cnt  <= cnt - 2'd1;
                    else              lo_q <= sram_dq_i;
                end
                HI_STROBE: begin
                    if (!strobe_last) begin
                        cnt <= cnt - 2'd1;
                    end else if (grant == PORT_D) begin
                        // Ack is registered so it and the read word appear together in DONE.
                        d_ack <= 1'b1;
                        if (!we_q) d_rdata <= {sram_dq_i, lo_q};
                    end else begin
                        i_ack   <= 1'b1;
                        i_rdata <= {sram_dq_i, lo_q};
                    end
                end
                DONE:    last_grant <= grant;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed cases plus a randomized mix
// checked against a word-level memory model and round-robin grant rule.
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    localparam int W0 = 0;
    localparam int W2 = 2;
    localparam int LAT    = 2 * (2 + W0) + 1;
    localparam int PERIOD = 2 * (2 + W0) + 2;
    localparam int LAT_B  = 2 * (2 + W2) + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic               i_req, i_ack, d_req, d_we, d_ack;
    logic [WORD_AW-1:0] i_addr, d_addr;
    logic [31:0]        i_rdata, d_rdata, d_wdata;
    logic [3:0]         d_be;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_i, sram_dq_o;
    logic               sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    logic               i_req_b, i_ack_b, d_req_b, d_we_b, d_ack_b;
    logic [WORD_AW-1:0] i_addr_b, d_addr_b;
    logic [31:0]        i_rdata_b, d_rdata_b, d_wdata_b;
    logic [3:0]         d_be_b;
    logic [SRAM_AW-1:0] sram_addr_b;
    logic [15:0]        sram_dq_i_b, sram_dq_o_b;
    logic               sram_dq_oe_b, sram_ce_n_b, sram_oe_n_b, sram_we_n_b, sram_ub_n_b, sram_lb_n_b;

    sram_arbiter #(.WAIT_STATES(W0)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .sram_addr(sram_addr), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    sram_arbiter #(.WAIT_STATES(W2)) dut_b (
        .clk(clk), .reset(reset),
        .i_req(i_req_b), .i_addr(i_addr_b), .i_ack(i_ack_b), .i_rdata(i_rdata_b),
        .d_req(d_req_b), .d_we(d_we_b), .d_be(d_be_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
        .d_ack(d_ack_b), .d_rdata(d_rdata_b),
        .sram_addr(sram_addr_b), .sram_dq_i(sram_dq_i_b), .sram_dq_o(sram_dq_o_b),
        .sram_dq_oe(sram_dq_oe_b), .sram_ce_n(sram_ce_n_b), .sram_oe_n(sram_oe_n_b),
        .sram_we_n(sram_we_n_b), .sram_ub_n(sram_ub_n_b), .sram_lb_n(sram_lb_n_b)
    );

    // Asynchronous SRAM model: reads drive data only while selected and output-enabled.
    logic [15:0] mem [0:(1 << SRAM_AW) - 1];
    assign sram_dq_i   = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'hDEAD;
    assign sram_dq_i_b = !sram_oe_n_b ? (sram_addr_b[15:0] ^ 16'h5A5A) : 16'hDEAD;

    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) mem[sram_addr][7:0]  = sram_dq_o[7:0];
            if (!sram_ub_n) mem[sram_addr][15:8] = sram_dq_o[15:8];
        end
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Bus monitor: contention, one-cycle acks, byte lanes of writes, strobe widths.
    bit   mon_en = 1'b0;
    logic prev_i_ack = 1'b0, prev_d_ack = 1'b0;
    int   we_low_cnt = 0, oe_b_lo = 0, oe_b_hi = 0;
    logic lo_ub, lo_lb, hi_ub, hi_lb;

    always @(negedge clk) begin
        if (mon_en) begin
            check("dq_oe_while_oe_n_low", 32'(sram_dq_oe & ~sram_oe_n), 32'd0);
            check("dq_oe_while_oe_n_low_b", 32'(sram_dq_oe_b & ~sram_oe_n_b), 32'd0);
            check("ack_one_cycle", 32'((i_ack & prev_i_ack) | (d_ack & prev_d_ack)), 32'd0);
            prev_i_ack = i_ack;
            prev_d_ack = d_ack;
            if (!sram_we_n) begin
                we_low_cnt++;
                if (sram_addr[0]) begin hi_ub = sram_ub_n; hi_lb = sram_lb_n; end
                else              begin lo_ub = sram_ub_n; lo_lb = sram_lb_n; end
            end
            if (!sram_oe_n_b) begin
                if (sram_addr_b[0]) oe_b_hi++;
                else                oe_b_lo++;
            end
        end
    end

    // Reference model: word memory and the bench's own record of the last grant.
    logic [31:0] ref_mem [0:15];
    port_t       last_g;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic set_word(input int w, input logic [31:0] v);
        logic [SRAM_AW-1:0] a;
        a = {17'(w), 1'b0};
        ref_mem[w] = v;
        mem[a]        = v[15:0];
        mem[a | 18'd1] = v[31:16];
    endtask

    task automatic do_txn(input bit ui, input bit ud, input logic [16:0] ia, input logic [16:0] da,
                          input bit we, input logic [3:0] be, input logic [31:0] wd);
        port_t first;
        int    t_i, t_d, cnt;
        bit    got_i, got_d;
        first = (ui && ud) ? ((last_g == PORT_I) ? PORT_D : PORT_I) : (ud ? PORT_D : PORT_I);
        @(negedge clk);
        i_req = ui; i_addr = ia;
        d_req = ud; d_addr = da; d_we = we; d_be = be; d_wdata = wd;
        got_i = !ui; got_d = !ud; t_i = -1; t_d = -1; cnt = 0;
        while (!(got_i && got_d) && cnt < 60) begin
            @(negedge clk);
            cnt++;
            check("i_ack_spurious", 32'(i_ack & got_i), 32'd0);
            check("d_ack_spurious", 32'(d_ack & got_d), 32'd0);
            if (i_ack && !got_i) begin
                got_i = 1'b1; i_req = 1'b0; t_i = cnt;
                check("i_rdata", i_rdata, ref_mem[ia[3:0]]);
            end
            if (d_ack && !got_d) begin
                got_d = 1'b1; d_req = 1'b0; t_d = cnt;
                if (we) ref_mem[da[3:0]] = merge(ref_mem[da[3:0]], wd, be);
                else    check("d_rdata", d_rdata, ref_mem[da[3:0]]);
            end
        end
        check("txn_complete", 32'({got_i, got_d}), 32'd3);
        i_req = 1'b0; d_req = 1'b0;
        if (ui && ud) begin
            check("first_latency", 32'((first == PORT_I) ? t_i : t_d), 32'(LAT));
            check("second_latency", 32'((first == PORT_I) ? t_d : t_i), 32'(LAT + PERIOD));
            last_g = (first == PORT_I) ? PORT_D : PORT_I;
        end else if (ui) begin
            check("i_latency", 32'(t_i), 32'(LAT));
            last_g = PORT_I;
        end else begin
            check("d_latency", 32'(t_d), 32'(LAT));
            last_g = PORT_D;
        end
    endtask

    initial begin
        int          cnt;
        bit          seen;
        logic [17:0] lo_a, hi_a;

        reset = 1'b1;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        i_req_b = 0; i_addr_b = 0; d_req_b = 0; d_we_b = 0; d_be_b = 0; d_addr_b = 0; d_wdata_b = 0;
        last_g = PORT_I;
        for (int w = 0; w < 16; w++) set_word(w, $urandom);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1F);
        check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_dq_o", 32'(sram_dq_o), 32'd0);
        check("rst_acks", 32'({i_ack, d_ack}), 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        mon_en = 1'b1;

        // Directed read: halfwords 0x10/0x11 form data word 8.
        mem[18'h00010] = 16'h1234;
        mem[18'h00011] = 16'hABCD;
        ref_mem[8] = 32'hABCD1234;
        do_txn(1'b0, 1'b1, 17'd0, 17'd8, 1'b0, 4'h0, 32'h0);
        check("read_word8", d_rdata, 32'hABCD1234);
        check("read_no_we", 32'(we_low_cnt), 32'd0);

        // Byte-masked write to a zeroed word, then read it back.
        set_word(3, 32'h0);
        lo_ub = 1'bx; lo_lb = 1'bx; hi_ub = 1'bx; hi_lb = 1'bx;
        do_txn(1'b0, 1'b1, 17'd0, 17'd3, 1'b1, 4'b0110, 32'hAABBCCDD);
        check("lo_lanes", 32'({lo_ub, lo_lb}), 32'b01);
        check("hi_lanes", 32'({hi_ub, hi_lb}), 32'b10);
        do_txn(1'b0, 1'b1, 17'd0, 17'd3, 1'b0, 4'h0, 32'h0);
        check("bytemask_readback", d_rdata, 32'h00BBCC00);

        // Simultaneous requests: the grant order is checked through latencies.
        last_g = PORT_I;
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        for (int k = 0; k < 3; k++)
            do_txn(1'b1, 1'b1, 17'($urandom_range(0, 15)), 17'($urandom_range(0, 15)),
                   1'b0, 4'h0, 32'h0);

        // WAIT_STATES=2 instance: three strobe cycles per half, ack in cycle 9.
        oe_b_lo = 0; oe_b_hi = 0;
        @(negedge clk);
        d_req_b = 1'b1; d_addr_b = 17'h00123;
        lo_a = {17'h00123, 1'b0};
        hi_a = {17'h00123, 1'b1};
        cnt = 0;
        while (!d_ack_b && cnt < 40) begin @(negedge clk); cnt++; end
        d_req_b = 1'b0;
        check("ws2_ack_cycle", 32'(cnt), 32'(LAT_B));
        check("ws2_rdata", d_rdata_b, {hi_a[15:0] ^ 16'h5A5A, lo_a[15:0] ^ 16'h5A5A});
        check("ws2_oe_lo_cycles", 32'(oe_b_lo), 32'd3);
        check("ws2_oe_hi_cycles", 32'(oe_b_hi), 32'd3);

        // Reset during the high-half write strobe.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 17'd5; d_be = 4'hF; d_wdata = 32'h13579BDF;
        cnt = 0; seen = 1'b0;
        while (!seen && cnt < 20) begin
            @(negedge clk); cnt++;
            seen = !sram_we_n && sram_addr[0];
        end
        check("reached_hi_strobe", 32'(seen), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1F);
        check("rst_mid_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_mid_no_ack", 32'(d_ack), 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        last_g = PORT_I;
        repeat (3) begin
            @(negedge clk);
            check("rst_mid_no_ack_after", 32'(d_ack), 32'd0);
        end
        set_word(5, 32'hC0FFEE05);

        // Randomized mix of single and contending requests.
        for (int n = 0; n < 600; n++) begin
            int sel;
            sel = $urandom_range(0, 2);
            do_txn(sel != 1, sel != 0, 17'($urandom_range(0, 15)), 17'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 4'($urandom), $urandom);
        end

        @(negedge clk);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
